// File: rtl/sync_fifo_pf.sv
// sync_fifo_pf: single-clock FIFO with occupancy count, almost thresholds and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a 1-cycle registered read.
module sync_fifo_pf #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 6,
  parameter int AFULL_THRESH  = 56,
  parameter int AEMPTY_THRESH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
  localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
  logic                  rd_acc, wr_acc;

  // Flags come only from registered count, never from the request inputs.
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) rd_ptr <= rd_ptr + ONE;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
      // A fresh error outranks a same-cycle clear.
      overflow  <= (wr_en & ~wr_acc) | (overflow  & ~err_clr);
      underflow <= (rd_en & ~rd_acc) | (underflow & ~err_clr);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rd_data  = mem[rd_ptr[ADDR_WIDTH-1:0]];
  assign rd_valid = ~empty;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
    end
  end
`endif

  // Wrap bits are kept for debug visibility; occupancy lives in count.
  logic unused_wrap;
  assign unused_wrap = wr_ptr[ADDR_WIDTH] ^ rd_ptr[ADDR_WIDTH];

endmodule

// File: tb/tb_sync_fifo_pf.sv
// Bench for sync_fifo_pf: queue-based reference model checked every cycle plus directed literals.
module tb_sync_fifo_pf;
  localparam int DEPTH = 64;

  logic       clk, rst_n, wr_en, rd_en, err_clr;
  logic [7:0] wr_data, rd_data;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [6:0] count;

  sync_fifo_pf dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  // Reference model: contents as a queue, plus last popped word and error flags.
  logic [7:0] q[$];
  logic       m_rv, m_ovf, m_unf;
  logic [7:0] m_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_rv = 1'b0; m_rd = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  // Drive one cycle; the model advances on the edge, then we park on the falling edge.
  task automatic step(input logic we, input logic [7:0] wd, input logic re, input logic ec);
    logic racc, wacc;
    wr_en = we; wr_data = wd; rd_en = re; err_clr = ec;
    @(posedge clk);
    racc = re && (q.size() != 0);
    wacc = we && ((q.size() < DEPTH) || racc);
    m_rv = racc;
    if (racc) m_rd = q.pop_front();
    if (wacc) q.push_back(wd);
    m_ovf = (we && !wacc) || (m_ovf && !ec);
    m_unf = (re && !racc) || (m_unf && !ec);
    @(negedge clk);
  endtask

  task automatic compare();
    chk("count", count, q.size());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
    chk("almost_full", almost_full, q.size() >= 56);
    chk("almost_empty", almost_empty, q.size() <= 8);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_unf);
`ifdef SYNC_FIFO_FWFT_EN
    chk("rd_valid", rd_valid, q.size() != 0);
    if (q.size() != 0) chk("rd_data", rd_data, q[0]);
`else
    chk("rd_valid", rd_valid, m_rv);
    chk("rd_data", rd_data, m_rd);
`endif
  endtask

  always @(negedge clk) if (chk_en && rst_n) compare();

  initial begin
    int nq;
    logic we, re;
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = 8'h00;
    model_clear();
    @(negedge clk); @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rst_rdata", rd_data, 0);
`endif
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Async reset pulse in the middle of traffic.
    for (int i = 0; i < 10; i++) step(1'b1, 8'(i + 8'h10), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("pre_rst_ovf", overflow, 0);
    wr_en = 1'b0; rd_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("pulse_count", count, 0);
    chk("pulse_empty", empty, 1);
    chk("pulse_valid", rd_valid, 0);
    chk("pulse_ovf", overflow, 0);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);

    // Fill to full, then one rejected write.
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill_count", count, i + 1);
      chk("fill_aempty", almost_empty, i < 8);
      chk("fill_afull", almost_full, i >= 55);
      chk("fill_full", full, i == 63);
    end
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("ovf_count", count, 64);
    chk("ovf_flag", overflow, 1);

    // Drain in order, then one rejected read, then clear errors.
    for (int i = 0; i < 64; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      chk("drain_data", rd_data, i);
      step(1'b0, 8'h00, 1'b1, 1'b0);
`else
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_data", rd_data, i);
      chk("drain_valid", rd_valid, 1);
`endif
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("unf_flag", underflow, 1);
    chk("unf_empty", empty, 1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("unf_valid", rd_valid, 0);
`endif
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_ovf", overflow, 0);
    chk("clr_unf", underflow, 0);

    // Full with simultaneous write and read.
    for (int i = 0; i < 64; i++) step(1'b1, 8'(i + 8'h40), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    chk("fwr_count", count, 64);
    chk("fwr_ovf", overflow, 0);
    chk("fwr_full", full, 1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("fwr_data", rd_data, 8'h40);
`endif
    for (int i = 0; i < 64; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      if (i == 63) chk("last_aa", rd_data, 8'hAA);
      step(1'b0, 8'h00, 1'b1, 1'b0);
`else
      step(1'b0, 8'h00, 1'b1, 1'b0);
      if (i == 63) chk("last_aa", rd_data, 8'hAA);
`endif
    end
    chk("fwr_empty", empty, 1);

    // Empty with simultaneous write and read.
    step(1'b1, 8'h5C, 1'b1, 1'b0);
    chk("ewr_count", count, 1);
    chk("ewr_unf", underflow, 1);
    chk("ewr_ovf", overflow, 0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("ewr_data", rd_data, 8'h5C);
    chk("ewr_valid", rd_valid, 1);
`else
    chk("ewr_valid", rd_valid, 0);
`endif
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("ewr_clr", underflow, 0);
    chk("ewr_count2", count, 0);

    // Random traffic held between 20 and 40 words, crossing pointer wrap.
    for (int i = 0; i < 30; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int k = 0; k < 200; k++) begin
      nq = q.size();
      we = (nq < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
      re = (nq > 20) ? 1'($urandom_range(0, 1)) : 1'b0;
      step(we, 8'($urandom), re, 1'b0);
    end
    chk("rand_ovf", overflow, 0);
    chk("rand_unf", underflow, 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
